// File: rtl/register_file.sv
// Architectural register file with per-register busy flag and RoB rename tag.
// Optional same-cycle commit bypass on the read ports: define REGFILE_BYPASS_EN.
module register_file #(
  parameter int unsigned ROB_BITS = 4
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic [4:0]          issue_rd,
  input  logic [ROB_BITS-1:0] issue_tag,
  input  logic [4:0]          commit_rd,
  input  logic [31:0]         commit_value,
  input  logic [ROB_BITS-1:0] commit_tag,
  input  logic                flush,
  input  logic [4:0]          rs1_id,
  input  logic [4:0]          rs2_id,
  output logic [31:0]         rs1_value,
  output logic [31:0]         rs2_value,
  output logic                rs1_busy,
  output logic                rs2_busy,
  output logic [ROB_BITS-1:0] rs1_tag,
  output logic [ROB_BITS-1:0] rs2_tag
);

  logic [31:0]         r_val  [32];
  logic [ROB_BITS-1:0] r_tag  [32];
  logic [31:0]         r_busy;

  logic w_commit_en;
  logic w_release;
  logic w_issue_en;

  assign w_commit_en = (commit_rd != 5'd0);
  // Only the newest producer may release the busy flag.
  assign w_release   = w_commit_en && r_busy[commit_rd] && (r_tag[commit_rd] == commit_tag);
  assign w_issue_en  = (issue_rd != 5'd0) && !flush;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < 32; i++) begin
        r_val[i] <= '0;
        r_tag[i] <= '0;
      end
      r_busy <= '0;
    end else if (rdy_in) begin
      if (w_commit_en) begin
        r_val[commit_rd] <= commit_value;
      end
      if (flush) begin
        r_busy <= '0;
      end else begin
        if (w_release) begin
          r_busy[commit_rd] <= 1'b0;
        end
        // Rename written last so it wins over a release of the same register.
        if (w_issue_en) begin
          r_busy[issue_rd] <= 1'b1;
          r_tag[issue_rd]  <= issue_tag;
        end
      end
    end
  end

  logic w_hit1;
  logic w_hit2;

`ifdef REGFILE_BYPASS_EN
  assign w_hit1 = rdy_in && (rs1_id != 5'd0) && (rs1_id == commit_rd) && r_busy[rs1_id] &&
                  (r_tag[rs1_id] == commit_tag);
  assign w_hit2 = rdy_in && (rs2_id != 5'd0) && (rs2_id == commit_rd) && r_busy[rs2_id] &&
                  (r_tag[rs2_id] == commit_tag);
`else
  assign w_hit1 = 1'b0;
  assign w_hit2 = 1'b0;
`endif

  always_comb begin
    rs1_value = r_val[rs1_id];
    rs1_busy  = r_busy[rs1_id];
    rs1_tag   = r_tag[rs1_id];
    rs2_value = r_val[rs2_id];
    rs2_busy  = r_busy[rs2_id];
    rs2_tag   = r_tag[rs2_id];
    if (w_hit1) begin
      rs1_value = commit_value;
      rs1_busy  = 1'b0;
    end
    if (w_hit2) begin
      rs2_value = commit_value;
      rs2_busy  = 1'b0;
    end
  end

endmodule
